mant_div_seq: RTL and testbench



---
 rtl/mant_div_seq.sv | 187 ++++++++++++++++++
 tb/tb_mant_div_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mant_div_seq.sv
// mant_div_seq: multi-cycle restoring divider for floating-point mantissas.
// Produces Q = floor(A*2^(QUO_W-1)/B), the final remainder and a sticky bit,
// with valid/ready on the operand side and valid/ack on the result side.
// Optional feature macro: MANT_DIV_EARLY_TERM_EN. When it is defined, the
// calculation finishes as soon as the partial remainder reaches zero, and the
// remaining quotient LSBs are filled with zeros.
module mant_div_seq #(
    parameter int MANT_W         = 24,
    parameter int QUO_W          = 26,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_valid,
    output logic              out_ready,
    input  logic [MANT_W-1:0] in_dividend,
    input  logic [MANT_W-1:0] in_divisor,
    output logic              out_valid,
    input  logic              in_ack,
    output logic [QUO_W-1:0]  out_quotient,
    output logic [MANT_W-1:0] out_remainder,
    output logic              out_sticky,
    output logic              out_dbz,
    output logic              out_ovf,
    output logic              out_busy
);

    localparam int N_CYC = QUO_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N_CYC + 1);

    // Reject unsupported step widths at elaboration time.
    generate
        if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2)) ||
            ((QUO_W % BITS_PER_CYCLE) != 0)) begin : g_param_err
            $error("mant_div_seq: BITS_PER_CYCLE must be 1 or 2 and divide QUO_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [QUO_W-1:0]  quo_q, quo_d;
    logic [MANT_W:0]   rem_q, rem_d;
    logic [MANT_W-1:0] div_q, div_d;
    logic              sticky_q, sticky_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;

    logic [QUO_W-1:0]  quo_step_s;
    logic [MANT_W:0]   rem_step_s;
    logic              last_cycle_s;

    // One clock's worth of restoring steps on the held remainder; the last
    // quotient bit of the whole operation leaves the remainder unshifted.
    always_comb begin
        quo_step_s   = quo_q;
        rem_step_s   = rem_q;
        last_cycle_s = (cnt_q == CNT_W'(1));
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_step_s >= {1'b0, div_q}) begin
                rem_step_s = rem_step_s - {1'b0, div_q};
                quo_step_s = {quo_step_s[QUO_W-2:0], 1'b1};
            end else begin
                quo_step_s = {quo_step_s[QUO_W-2:0], 1'b0};
            end
            if (last_cycle_s && (i == BITS_PER_CYCLE - 1)) begin
                rem_step_s = rem_step_s;
            end else begin
                rem_step_s = {rem_step_s[MANT_W-1:0], 1'b0};
            end
        end
    end

    // Control FSM and datapath next-state: accept, iterate, hold result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d = in_divisor;
                    if (in_divisor == {MANT_W{1'b0}}) begin
                        state_d  = S_DONE;
                        dbz_d    = 1'b1;
                        ovf_d    = 1'b0;
                        quo_d    = {QUO_W{1'b1}};
                        rem_d    = {(MANT_W+1){1'b0}};
                        sticky_d = 1'b1;
                    end else if ({1'b0, in_dividend} >= {in_divisor, 1'b0}) begin
                        state_d  = S_DONE;
                        dbz_d    = 1'b0;
                        ovf_d    = 1'b1;
                        quo_d    = {QUO_W{1'b1}};
                        rem_d    = {(MANT_W+1){1'b0}};
                        sticky_d = 1'b1;
                    end else begin
                        state_d  = S_CALC;
                        dbz_d    = 1'b0;
                        ovf_d    = 1'b0;
                        quo_d    = {QUO_W{1'b0}};
                        rem_d    = {1'b0, in_dividend};
                        sticky_d = 1'b0;
                        cnt_d    = CNT_W'(N_CYC);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                quo_d = quo_step_s;
                rem_d = rem_step_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_cycle_s) begin
                    state_d  = S_DONE;
                    sticky_d = (rem_step_s != {(MANT_W+1){1'b0}});
                end else begin
`ifdef MANT_DIV_EARLY_TERM_EN
                    if (rem_step_s == {(MANT_W+1){1'b0}}) begin
                        // Remaining quotient bits are all zero; align Q now.
                        state_d  = S_DONE;
                        quo_d    = quo_step_s << ((int'(cnt_q) - 1) * BITS_PER_CYCLE);
                        sticky_d = 1'b0;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_DONE: begin
                if (in_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            quo_q    <= {QUO_W{1'b0}};
            rem_q    <= {(MANT_W+1){1'b0}};
            div_q    <= {MANT_W{1'b0}};
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_ready     = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign out_busy      = (state_q == S_CALC);
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q[MANT_W-1:0];
    assign out_sticky    = sticky_q;
    assign out_dbz       = dbz_q;
    assign out_ovf       = ovf_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq: directed vector table, random
// operands against an arithmetic reference, handshake and reset sequences.
// A second instance with BITS_PER_CYCLE=2 runs in lockstep on the same inputs.
module tb_mant_div_seq;

    localparam int MW = 24;
    localparam int QW = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_ack;
    logic [MW-1:0] a_s;
    logic [MW-1:0] b_s;

    logic          rdy1, vld1, st1, dz1, ov1, busy1;
    logic [QW-1:0] q1;
    logic [MW-1:0] r1;
    logic          rdy2, vld2, st2, dz2, ov2, busy2;
    logic [QW-1:0] q2;
    logic [MW-1:0] r2;

    int total = 0;
    int bad   = 0;

    mant_div_seq #(.MANT_W(MW), .QUO_W(QW), .BITS_PER_CYCLE(1)) u_dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_ready(rdy1),
        .in_dividend(a_s), .in_divisor(b_s), .out_valid(vld1), .in_ack(in_ack),
        .out_quotient(q1), .out_remainder(r1), .out_sticky(st1),
        .out_dbz(dz1), .out_ovf(ov1), .out_busy(busy1)
    );

    mant_div_seq #(.MANT_W(MW), .QUO_W(QW), .BITS_PER_CYCLE(2)) u_dut2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_ready(rdy2),
        .in_dividend(a_s), .in_divisor(b_s), .out_valid(vld2), .in_ack(in_ack),
        .out_quotient(q2), .out_remainder(r2), .out_sticky(st2),
        .out_dbz(dz2), .out_ovf(ov2), .out_busy(busy2)
    );

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        longint        q;
        longint        r;
        bit            st;
        bit            dz;
        bit            ov;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division of A*2^(QW-1) by B, plus latency.
    task automatic model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                         output longint q, output longint r, output bit st,
                         output bit dz, output bit ov, output int lat1, output int lat2);
        longint num;
        longint bb;
        bit     found;
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            dz = 1'b1; q = 64'h3FFFFFF; r = 0; st = 1'b1; lat1 = 0; lat2 = 0;
        end else if (longint'(a) >= 2 * longint'(b)) begin
            ov = 1'b1; q = 64'h3FFFFFF; r = 0; st = 1'b1; lat1 = 0; lat2 = 0;
        end else begin
            bb   = longint'(b);
            num  = longint'(a) << (QW - 1);
            q    = num / bb;
            r    = num % bb;
            st   = (r != 0);
            lat1 = QW;
            lat2 = QW / 2;
            found = 1'b0;
`ifdef MANT_DIV_EARLY_TERM_EN
            for (int j = 1; j <= QW; j++) begin
                if (!found && (((longint'(a) << (j - 1)) % bb) == 0)) begin
                    found = 1'b1;
                    lat1  = j;
                    lat2  = (j + 1) / 2;
                end
            end
`endif
        end
    endtask

    // Accept one operation, time out_valid on both instances, check, acknowledge.
    task automatic run_op(input string nm, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input longint eq, input longint er, input bit est,
                          input bit edz, input bit eov);
        longint mq, mr;
        bit     mst, mdz, mov;
        int     el1, el2, lat1, lat2;
        model(a, b, mq, mr, mst, mdz, mov, el1, el2);
        chk({nm, " ready_in"}, rdy1, 1);
        in_valid = 1'b1;
        a_s = a;
        b_s = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_s = 24'($urandom());
        b_s = 24'($urandom());
        lat1 = -1;
        lat2 = -1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (vld1 && lat1 < 0) lat1 = c;
            if (vld2 && lat2 < 0) lat2 = c;
            if (lat1 >= 0 && lat2 >= 0) break;
        end
        chk({nm, " lat1"}, lat1, el1);
        chk({nm, " lat2"}, lat2, el2);
        chk({nm, " q1"}, q1, eq);
        chk({nm, " r1"}, r1, er);
        chk({nm, " st1"}, st1, est);
        chk({nm, " dbz1"}, dz1, edz);
        chk({nm, " ovf1"}, ov1, eov);
        chk({nm, " q2"}, q2, eq);
        chk({nm, " r2"}, r2, er);
        chk({nm, " st2"}, st2, est);
        chk({nm, " flags2"}, {dz2, ov2}, {edz, eov});
        in_ack = 1'b1;
        @(posedge clk); #1;
        in_ack = 1'b0;
        chk({nm, " valid_after_ack"}, vld1, 0);
        chk({nm, " ready_after_ack"}, {rdy1, rdy2}, 2'b11);
    endtask

    vec_t tbl[12];

    initial begin
        longint mq, mr;
        bit     mst, mdz, mov;
        int     l1, l2;
        logic [MW-1:0] ra, rb;

        tbl[0]  = '{24'h800000, 24'h800000, 64'h2000000, 64'h0,      1'b0, 1'b0, 1'b0};
        tbl[1]  = '{24'h800000, 24'hC00000, 64'h1555555, 64'h400000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{24'hC00000, 24'h800000, 64'h3000000, 64'h0,      1'b0, 1'b0, 1'b0};
        tbl[3]  = '{24'h900000, 24'h000000, 64'h3FFFFFF, 64'h0,      1'b1, 1'b1, 1'b0};
        tbl[4]  = '{24'h900000, 24'h000001, 64'h3FFFFFF, 64'h0,      1'b1, 1'b0, 1'b1};
        tbl[5]  = '{24'h000000, 24'h000001, 64'h0,       64'h0,      1'b0, 1'b0, 1'b0};
        tbl[6]  = '{24'h000001, 24'h000001, 64'h2000000, 64'h0,      1'b0, 1'b0, 1'b0};
        tbl[7]  = '{24'hFFFFFF, 24'h800000, 64'h3FFFFFC, 64'h0,      1'b0, 1'b0, 1'b0};
        tbl[8]  = '{24'h800000, 24'h400000, 64'h3FFFFFF, 64'h0,      1'b1, 1'b0, 1'b1};
        tbl[9]  = '{24'h7FFFFF, 24'h800000, 64'h1FFFFFC, 64'h0,      1'b0, 1'b0, 1'b0};
        tbl[10] = '{24'h000003, 24'h000002, 64'h3000000, 64'h0,      1'b0, 1'b0, 1'b0};
        tbl[11] = '{24'h000005, 24'h000003, 64'h3555555, 64'h1,      1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_ack = 1'b0; a_s = '0; b_s = '0;
        #1;
        chk("reset ready", {rdy1, rdy2}, 2'b11);
        chk("reset valid", {vld1, vld2}, 2'b00);
        chk("reset busy", {busy1, busy2}, 2'b00);
        chk("reset q", q1, 0);
        chk("reset r", r1, 0);
        chk("reset flags", {st1, dz1, ov1}, 3'b000);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                   tbl[i].st, tbl[i].dz, tbl[i].ov);
        end

        for (int k = 0; k < 40; k++) begin
            ra = 24'($urandom());
            rb = 24'($urandom());
            if (k % 3 != 0) begin
                ra = ra | 24'h800000;
                rb = rb | 24'h800000;
            end
            if (k % 11 == 5) rb = 24'h000000;
            if (k % 13 == 7) rb = rb & 24'h0000FF;
            model(ra, rb, mq, mr, mst, mdz, mov, l1, l2);
            run_op($sformatf("rnd%0d", k), ra, rb, mq, mr, mst, mdz, mov);
        end

        // Result held while in_ack is low; new operands are not taken.
        in_valid = 1'b1; a_s = 24'hC00000; b_s = 24'h800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !vld1; c++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            a_s = 24'($urandom()) | 24'h800000;
            b_s = 24'($urandom()) | 24'h800000;
            @(posedge clk); #1;
            chk($sformatf("hold%0d q", k), q1, 64'h3000000);
            chk($sformatf("hold%0d valid", k), vld1, 1);
            chk($sformatf("hold%0d ready", k), rdy1, 0);
        end
        in_valid = 1'b0;
        in_ack = 1'b1;
        @(posedge clk); #1;
        in_ack = 1'b0;
        chk("hold release valid", vld1, 0);
        chk("hold release ready", rdy1, 1);
        run_op("after_hold", 24'h800000, 24'hC00000, 64'h1555555, 64'h400000, 1'b1, 1'b0, 1'b0);

        // Reset asserted in the middle of a calculation.
        in_valid = 1'b1; a_s = 24'h800000; b_s = 24'hC00000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("midcalc busy", busy1, 1);
        rst_n = 1'b0;
        #1;
        chk("abort ready", {rdy1, rdy2}, 2'b11);
        chk("abort valid_busy", {vld1, vld2, busy1, busy2}, 4'b0000);
        chk("abort q", q1, 0);
        chk("abort r", r1, 0);
        chk("abort flags", {st1, dz1, ov1, st2, dz2, ov2}, 6'b000000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset", 24'hC00000, 24'h800000, 64'h3000000, 64'h0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
